sram_bus_arbiter: RTL and testbench

Two-master arbiter that shares one SRAM-like memory port between the instruction-fetch requester and the data-access requester of the pipeline. It grants the port with round-robin priority and latches the winner's request fields. It then sequences the transaction through address and data phases and routes the response back to the owner. The block sits between the IF/MEM stages and the single memory bridge, and allows only one transaction in flight.

---
 rtl/sram_bus_arbiter.sv | 121 ++++++++++++
 tb/tb_sram_bus_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bus_arbiter.sv
// Two-master arbiter sharing one SRAM-like memory port between the
// instruction-fetch and data-access requesters. Round-robin on ties,
// one transaction in flight, fields latched at grant.
module sram_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  // instruction-fetch requester
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [3:0]        inst_wstrb,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  // data-access requester
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  // memory port
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [3:0]        mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP
  } state_t;

  state_t state, state_nxt;
  logic   owner;       // 0 = inst, 1 = data
  logic   last;        // last granted master
  logic   any_req;
  logic   grant_data;

  // Arbitration: a lone requester wins; on a tie the master that was not
  // granted last time wins.
  always_comb begin
    any_req    = inst_req | data_req;
    grant_data = data_req & (~inst_req | ~last);
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; stray handshakes outside their phase are ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (any_req)     state_nxt = S_REQ;
      S_REQ:  if (mem_addr_ok) state_nxt = S_RESP;
      S_RESP: if (mem_data_ok) state_nxt = S_IDLE;
      default:                 state_nxt = S_IDLE;
    endcase
  end

  // Grant bookkeeping and request field capture, only at the grant edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner     <= 1'b0;
      last      <= 1'b0;
      mem_wr    <= 1'b0;
      mem_size  <= '0;
      mem_wstrb <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (state == S_IDLE && any_req) begin
      owner <= grant_data;
      last  <= grant_data;
      if (grant_data) begin
        mem_wr    <= data_wr;
        mem_size  <= data_size;
        mem_wstrb <= data_wstrb;
        mem_addr  <= data_addr;
        mem_wdata <= data_wdata;
      end else begin
        mem_wr    <= inst_wr;
        mem_size  <= inst_size;
        mem_wstrb <= inst_wstrb;
        mem_addr  <= inst_addr;
        mem_wdata <= inst_wdata;
      end
    end
  end

  // Handshake routing back to the owner; read data is a plain fan-out.
  always_comb begin
    mem_req      = (state == S_REQ);
    inst_addr_ok = (state == S_REQ)  & mem_addr_ok & ~owner;
    data_addr_ok = (state == S_REQ)  & mem_addr_ok &  owner;
    inst_data_ok = (state == S_RESP) & mem_data_ok & ~owner;
    data_data_ok = (state == S_RESP) & mem_data_ok &  owner;
    inst_rdata   = mem_rdata;
    data_rdata   = mem_rdata;
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Self-checking bench for sram_bus_arbiter: directed scenarios followed by
// randomized traffic, all checked against a transaction-phase model.
module tb_sram_bus_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  sram_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: phase of the single in-flight transaction
  // (0 = none, 1 = waiting for acceptance, 2 = waiting for response).
  int          m_phase;
  logic        m_who, m_last;
  logic        m_wr;
  logic [1:0]  m_size;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata;
  logic        last_iaok, last_daok;

  // Observation log.
  int          cnt_memreq, cnt_iaok, cnt_daok, cnt_idok, cnt_ddok;
  int          gn;
  int          gwho   [8];
  logic [31:0] gaddr  [8];
  logic [31:0] gwdata [8];
  logic        gwr    [8];
  logic [1:0]  gsize  [8];
  logic [3:0]  gwstrb [8];
  logic [31:0] cap_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_who = 1'b0; m_last = 1'b0;
    m_wr = 1'b0; m_size = '0; m_wstrb = '0; m_addr = '0; m_wdata = '0;
    last_iaok = 1'b0; last_daok = 1'b0;
  endtask

  task automatic clr();
    cnt_memreq = 0; cnt_iaok = 0; cnt_daok = 0; cnt_idok = 0; cnt_ddok = 0;
    gn = 0; cap_rdata = 'x;
    for (int i = 0; i < 8; i++) begin
      gwho[i] = -1; gaddr[i] = 'x; gwdata[i] = 'x;
      gwr[i] = 1'bx; gsize[i] = 'x; gwstrb[i] = 'x;
    end
  endtask

  task automatic drive_idle();
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_wstrb = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
  endtask

  task automatic set_inst(input logic wr, input logic [1:0] sz, input logic [3:0] st,
                          input logic [31:0] a, input logic [31:0] d);
    inst_req = 1; inst_wr = wr; inst_size = sz; inst_wstrb = st; inst_addr = a; inst_wdata = d;
  endtask

  task automatic set_data(input logic wr, input logic [1:0] sz, input logic [3:0] st,
                          input logic [31:0] a, input logic [31:0] d);
    data_req = 1; data_wr = wr; data_size = sz; data_wstrb = st; data_addr = a; data_wdata = d;
  endtask

  // One clock: check outputs mid-cycle, log, advance the model, step past the edge.
  task automatic cycle();
    logic e_iaok, e_daok, e_idok, e_ddok, w;
    @(negedge clk);
    e_iaok = (m_phase == 1) && mem_addr_ok && !m_who;
    e_daok = (m_phase == 1) && mem_addr_ok &&  m_who;
    e_idok = (m_phase == 2) && mem_data_ok && !m_who;
    e_ddok = (m_phase == 2) && mem_data_ok &&  m_who;
    chk("mem_req",      mem_req,      m_phase == 1);
    chk("inst_addr_ok", inst_addr_ok, e_iaok);
    chk("data_addr_ok", data_addr_ok, e_daok);
    chk("inst_data_ok", inst_data_ok, e_idok);
    chk("data_data_ok", data_data_ok, e_ddok);
    chk("mem_wr",       mem_wr,       m_wr);
    chk("mem_size",     mem_size,     m_size);
    chk("mem_wstrb",    mem_wstrb,    m_wstrb);
    chk("mem_addr",     mem_addr,     m_addr);
    chk("mem_wdata",    mem_wdata,    m_wdata);
    chk("inst_rdata",   inst_rdata,   mem_rdata);
    chk("data_rdata",   data_rdata,   mem_rdata);
    cnt_memreq += int'(mem_req);
    cnt_iaok   += int'(inst_addr_ok);
    cnt_daok   += int'(data_addr_ok);
    cnt_idok   += int'(inst_data_ok);
    cnt_ddok   += int'(data_data_ok);
    if ((inst_addr_ok || data_addr_ok) && gn < 8) begin
      gwho[gn] = data_addr_ok ? 1 : 0;
      gaddr[gn] = mem_addr; gwdata[gn] = mem_wdata;
      gwr[gn] = mem_wr; gsize[gn] = mem_size; gwstrb[gn] = mem_wstrb;
      gn++;
    end
    if (inst_data_ok) cap_rdata = inst_rdata;
    if (data_data_ok) cap_rdata = data_rdata;
    if (!resetn) begin
      model_reset();
    end else if (m_phase == 0) begin
      if (inst_req || data_req) begin
        w = (inst_req && data_req) ? !m_last : data_req;
        m_who = w; m_last = w; m_phase = 1;
        if (w) begin
          m_wr = data_wr; m_size = data_size; m_wstrb = data_wstrb;
          m_addr = data_addr; m_wdata = data_wdata;
        end else begin
          m_wr = inst_wr; m_size = inst_size; m_wstrb = inst_wstrb;
          m_addr = inst_addr; m_wdata = inst_wdata;
        end
      end
    end else if (m_phase == 1) begin
      if (mem_addr_ok) m_phase = 2;
    end else begin
      if (mem_data_ok) m_phase = 0;
    end
    last_iaok = e_iaok;
    last_daok = e_daok;
    @(posedge clk);
    #1;
  endtask

  // Run one transaction from IDLE: grant, stall, accept, wait, respond.
  task automatic serve(input int stall, input int rdelay, input logic [31:0] rd,
                       input bit toggle_other);
    cycle();
    for (int i = 0; i < stall; i++) begin
      if (toggle_other) begin
        if (!m_who) begin data_req = ~data_req; data_addr = $urandom; end
        else begin inst_req = ~inst_req; inst_addr = $urandom; end
      end
      cycle();
    end
    mem_addr_ok = 1;
    cycle();
    mem_addr_ok = 0;
    if (last_iaok) inst_req = 0;
    if (last_daok) data_req = 0;
    for (int i = 0; i < rdelay; i++) cycle();
    mem_data_ok = 1; mem_rdata = rd;
    cycle();
    mem_data_ok = 0;
  endtask

  initial begin
    resetn = 0;
    drive_idle();
    model_reset();
    clr();
    #2;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
    chk("rst_data_ok", {inst_data_ok, data_data_ok}, 0);
    @(posedge clk); #1;
    resetn = 1;

    // Tie right after reset goes to data, then inst, then data again.
    clr();
    set_inst(0, 2, 4'hF, 32'h1C00_0100, 0);
    set_data(0, 2, 4'hF, 32'h1C00_0200, 0);
    serve(0, 0, 32'h1111_1111, 0);
    serve(1, 0, 32'h2222_2222, 0);
    set_inst(0, 2, 4'hF, 32'h1C00_0104, 0);
    set_data(0, 2, 4'hF, 32'h1C00_0204, 0);
    serve(0, 1, 32'h3333_3333, 0);
    inst_req = 0;
    chk("tie_count", gn, 3);
    chk("tie1_who", gwho[0], 1);
    chk("tie1_addr", gaddr[0], 32'h1C00_0200);
    chk("tie2_who", gwho[1], 0);
    chk("tie2_addr", gaddr[1], 32'h1C00_0100);
    chk("tie3_who", gwho[2], 1);
    chk("tie3_addr", gaddr[2], 32'h1C00_0204);

    // Single read.
    clr();
    set_inst(0, 2, 4'hF, 32'h1C00_0000, 0);
    serve(0, 1, 32'h0280_0C0C, 0);
    cycle();
    chk("rd_memreq_cycles", cnt_memreq, 1);
    chk("rd_inst_addr_ok", cnt_iaok, 1);
    chk("rd_inst_data_ok", cnt_idok, 1);
    chk("rd_data_addr_ok", cnt_daok, 0);
    chk("rd_rdata", cap_rdata, 32'h0280_0C0C);

    // Write path.
    clr();
    set_data(1, 0, 4'b0010, 32'h1C00_1001, 32'h0000_AB00);
    serve(0, 0, 32'hDEAD_BEEF, 0);
    chk("wr_who", gwho[0], 1);
    chk("wr_wr", gwr[0], 1);
    chk("wr_size", gsize[0], 0);
    chk("wr_wstrb", gwstrb[0], 4'b0010);
    chk("wr_addr", gaddr[0], 32'h1C00_1001);
    chk("wr_wdata", gwdata[0], 32'h0000_AB00);
    chk("wr_data_ok", cnt_ddok, 1);
    chk("wr_inst_idle", cnt_iaok + cnt_idok, 0);

    // Stalled memory with the non-owner toggling its request.
    clr();
    set_inst(0, 1, 4'b0011, 32'h1C00_2002, 0);
    serve(5, 1, 32'h5555_AAAA, 1);
    data_req = 0;
    chk("stall_memreq_cycles", cnt_memreq, 6);
    chk("stall_inst_addr_ok", cnt_iaok, 1);
    chk("stall_data_addr_ok", cnt_daok, 0);
    chk("stall_grant_addr", gaddr[0], 32'h1C00_2002);
    chk("stall_data_ok", cnt_idok + cnt_ddok, 1);

    // Stray responses in IDLE and REQ; same-cycle accept drops data_ok.
    clr();
    mem_data_ok = 1;
    cycle();
    set_inst(0, 2, 4'hF, 32'h1C00_3000, 0);
    cycle();
    cycle();
    mem_addr_ok = 1;
    cycle();
    mem_addr_ok = 0;
    inst_req = 0;
    cycle();
    mem_data_ok = 0;
    cycle();
    chk("stray_memreq_cycles", cnt_memreq, 2);
    chk("stray_data_ok", cnt_idok + cnt_ddok, 1);

    // Asynchronous reset in RESP.
    clr();
    set_inst(0, 2, 4'hF, 32'h1C00_4000, 0);
    cycle();
    mem_addr_ok = 1;
    cycle();
    mem_addr_ok = 0;
    inst_req = 0;
    cycle();
    mem_data_ok = 1;
    #2 resetn = 0;
    #1;
    chk("arst_mem_req", mem_req, 0);
    chk("arst_data_ok", {inst_data_ok, data_data_ok}, 0);
    chk("arst_mem_addr", mem_addr, 0);
    model_reset();
    cycle();
    resetn = 1;
    cycle();
    mem_data_ok = 0;
    clr();
    set_inst(0, 2, 4'hF, 32'h1C00_5000, 0);
    set_data(0, 2, 4'hF, 32'h1C00_6000, 0);
    serve(0, 0, 32'h0, 0);
    inst_req = 0;
    chk("arst_tie_who", gwho[0], 1);
    chk("arst_late_data_ok", cnt_idok, 0);

    // Randomized traffic.
    drive_idle();
    for (int n = 0; n < 1500; n++) begin
      if (!inst_req && ($urandom_range(0, 2) == 0))
        set_inst($urandom, $urandom_range(0, 2), $urandom, $urandom, $urandom);
      if (!data_req && ($urandom_range(0, 2) == 0))
        set_data($urandom, $urandom_range(0, 2), $urandom, $urandom, $urandom);
      mem_addr_ok = ($urandom_range(0, 1) == 0);
      mem_data_ok = ($urandom_range(0, 4) < 2);
      mem_rdata   = $urandom;
      cycle();
      if (last_iaok) inst_req = 0;
      if (last_daok) data_req = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
